// File: rtl/johnson_decoder.sv
// johnson_decoder
//   Decodes a WIDTH-bit Johnson (twisted-ring) count into its state number,
//   checks legality, and tracks whether successive valid samples step through
//   the sequence in order. Results are registered; latency is one clock.
//
// Parameters
//   WIDTH       Johnson code width (>= 2); the ring has 2*WIDTH states
//   SHIFT_LEFT  1: ring shifts left, inverted MSB enters at bit 0
//               0: ring shifts right, inverted LSB enters at the MSB
//
// Ports
//   clk         clock, rising edge
//   reset       asynchronous active-high reset
//   in_valid    code is sampled this cycle
//   code        Johnson-coded count to decode
//   clear       synchronous clear of tracker state, seq_err and counters
//   out_valid   result registers were updated by the previous edge
//   index       decoded state number 0..2*WIDTH-1 (0 when illegal)
//   legal       sampled code is a ring state
//   step_ok     sample is the successor of the previous legal sample
//   locked      tracker holds a reference sample
//   seq_err     sticky step/legality error flag
//   err_count   saturating error count
//   wrap_count  modulo-256 count of last-state -> state-0 transitions
module johnson_decoder #(
   parameter int WIDTH      = 4,
   parameter bit SHIFT_LEFT = 1'b1,
   localparam int IW        = $clog2(2*WIDTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   input  logic [WIDTH-1:0] code,
   input  logic          clear,
   output logic          out_valid,
   output logic [IW-1:0] index,
   output logic          legal,
   output logic          step_ok,
   output logic          locked,
   output logic          seq_err,
   output logic [7:0]    err_count,
   output logic [7:0]    wrap_count
);

   localparam logic [0:0]    IDLE  = 1'b0;
   localparam logic [0:0]    TRACK = 1'b1;
   localparam logic [IW-1:0] LAST  = IW'(2*WIDTH-1);

   logic [0:0]    state;
   logic [IW-1:0] prev;

   // One ring step in the configured direction.
   function automatic logic [WIDTH-1:0] ring_next(input logic [WIDTH-1:0] s);
      if (SHIFT_LEFT) return {s[WIDTH-2:0], ~s[WIDTH-1]};
      else            return {~s[0], s[WIDTH-1:1]};
   endfunction

   // Walk the ring from state 0 and match the code against every state;
   // a hit yields both legality and the index in one structure.
   logic          hit;
   logic [IW-1:0] dec;
   logic [WIDTH-1:0] walk;

   always_comb begin
      hit  = 1'b0;
      dec  = '0;
      walk = '0;
      for (int k = 0; k < 2*WIDTH; k++) begin
         if (code == walk) begin
            hit = 1'b1;
            dec = IW'(k);
         end
         walk = ring_next(walk);
      end
   end

   // clear in the same cycle as a sample makes that sample behave as an
   // IDLE-state sample against zeroed counters, so build the "base" view here.
   logic          track_eff;
   logic [7:0]    err_base, wrap_base, err_inc;
   logic [IW-1:0] succ;

   assign track_eff = (state == TRACK) && !clear;
   assign err_base  = clear ? 8'd0 : err_count;
   assign wrap_base = clear ? 8'd0 : wrap_count;
   assign err_inc   = (err_base == 8'hFF) ? 8'hFF : err_base + 8'd1;
   assign succ      = (prev == LAST) ? '0 : prev + IW'(1);
   assign locked    = (state == TRACK);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         prev       <= '0;
         out_valid  <= 1'b0;
         index      <= '0;
         legal      <= 1'b0;
         step_ok    <= 1'b0;
         seq_err    <= 1'b0;
         err_count  <= 8'd0;
         wrap_count <= 8'd0;
      end else begin
         out_valid <= in_valid;
         if (clear) begin
            state      <= IDLE;
            seq_err    <= 1'b0;
            err_count  <= 8'd0;
            wrap_count <= 8'd0;
         end
         // Sample handling below overrides the clear where both apply.
         if (in_valid) begin
            if (hit) begin
               index <= dec;
               legal <= 1'b1;
               prev  <= dec;
               state <= TRACK;
               if (track_eff && dec == succ) begin
                  step_ok <= 1'b1;
                  if (prev == LAST) wrap_count <= wrap_base + 8'd1;
               end else begin
                  step_ok <= 1'b0;
                  if (track_eff) begin
                     seq_err   <= 1'b1;
                     err_count <= err_inc;
                  end
               end
            end else begin
               index     <= '0;
               legal     <= 1'b0;
               step_ok   <= 1'b0;
               seq_err   <= 1'b1;
               err_count <= err_inc;
               state     <= IDLE;
            end
         end
      end
   end

endmodule
